dc_timing_gen: RTL
==================

// Module: dc_timing_gen
// PURPOSE
//  Display-controller raster timing generator; directly upstream of the DC pixel interface.
//  Pulls RGB888 pixels from a ready/valid source and emits pixel_data/data_valid/hsync/vsync.
//  Frame start: vsync and hsync rise together; hsync falls HSYNC_W cycles later;
//  data_valid rises HBP cycles after that (defaults 5/4, as the DC interface checker requires).
// PARAMETERS
//  H_ACTIVE  640  active pixels per line
//  HSYNC_W   5    hsync width, cycles (>=1)
//  HBP       4    horizontal back porch, cycles (>=1)
//  HFP       16   horizontal front porch, cycles (>=1)
//  V_ACTIVE  480  active lines per frame
//  VSYNC_W   2    vsync width, lines (1..V_ACTIVE)
//  VFP       10   vertical blank lines after active (>=1)
// PORTS
//  dc_clk         in   1   pixel clock
//  dc_rst         in   1   asynchronous, active-low reset
//  enable         in   1   run frames; sampled only at frame boundary
//  pix_in_data    in   24  source pixel {R,G,B}
//  pix_in_valid   in   1   source pixel valid
//  pix_in_ready   out  1   pixel consumed this cycle when valid&ready
//  pixel_data     out  24  registered pixel to DC interface
//  data_valid     out  1   registered active-video qualifier
//  hsync          out  1   registered line sync, active-high
//  vsync          out  1   registered frame sync, active-high
//  frame_start    out  1   one-cycle pulse, coincident with vsync rise
//  underflow      out  1   sticky: active slot occurred without pix_in_valid
//  clr_underflow  in   1   synchronous clear of underflow (wins over set)
// BEHAVIOUR
//  Reset (dc_rst=0): all outputs 0; h_cnt=v_cnt=0; FSM=IDLE. Mid-frame reset aborts immediately.
//  H_TOTAL=HSYNC_W+HBP+H_ACTIVE+HFP. V_TOTAL=V_ACTIVE+VFP. Counters sized by $clog2.
//  FSM IDLE->RUN when enable=1 (outputs rise next cycle at h=0,v=0).
//   RUN->IDLE only when h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 and enable=0; else wraps to h=0,v=0.
//   Deasserting enable mid-frame completes the current frame. IDLE: outputs 0, ready=0.
//  Line regions, by h_cnt: [0,HSYNC_W) sync; [HSYNC_W,+HBP) back porch; next H_ACTIVE active;
//   remainder front porch. h wraps at H_TOTAL-1 and v_cnt increments; v wraps at V_TOTAL-1.
//  Outputs are registered decodes of the counter value being entered (1-cycle latency):
//   hsync=1 in sync region of every line, incl. blank lines.
//   vsync=1 for every cycle of lines 0..VSYNC_W-1.
//   data_valid=1 in active region of lines 0..V_ACTIVE-1.
//  pix_in_ready=1 (comb.) in the cycle before each data_valid=1 cycle; pixel_data captures
//   pix_in_data on that edge if pix_in_valid, else captures 24'h0 and sets underflow.
//  pixel_data holds its last value while data_valid=0. Set and clr of underflow in same cycle: clear wins.
//  No backpressure from DC side; the timing never stalls on source starvation.
// TESTING (H_ACTIVE=8,HFP=3,V_ACTIVE=4,VFP=2,VSYNC_W=1 -> H_TOTAL=20, frame=120 cycles)
//  Reset release, enable=1 at T0 -> vsync/hsync/frame_start rise T0+1; hsync falls T0+6; data_valid T0+10..T0+17.
//  Source counting 1,2,3.. always valid -> pixel_data=1..8 on line 0, 9..16 on line 1; 32 pixels/frame, underflow=0.
//  Source valid withheld for 3rd pixel of line 0 -> that slot pixel_data=0, underflow=1 stays until clr_underflow.
//  enable dropped at cycle 50 -> frame completes to cycle T0+120, then all outputs 0, no further frame_start.
//  Steady run: frame_start period exactly 120; lines 4,5 have hsync pulses but no data_valid.
//  dc_rst asserted mid-active line -> outputs 0 asynchronously; restart gives T0+1/+6/+10 timing again.

Source files
------------

// File: rtl/dc_timing_gen_if.sv
// Pixel source handshake and raster output bundle.
// master: timing generator side, slave: source/sink side.
interface dc_timing_gen_if;
  logic [23:0] pix_in_data;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [23:0] pixel_data;
  logic        data_valid;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    input  pix_in_data,
    input  pix_in_valid,
    output pix_in_ready,
    output pixel_data,
    output data_valid,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    output pix_in_data,
    output pix_in_valid,
    input  pix_in_ready,
    input  pixel_data,
    input  data_valid,
    input  hsync,
    input  vsync,
    input  frame_start
  );
endinterface

// File: rtl/dc_timing_gen.sv
// Raster timing generator for the DC pixel interface.
// Pulls RGB888 pixels and emits registered sync/video timing.
module dc_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int HSYNC_W  = 5,
  parameter int HBP      = 4,
  parameter int HFP      = 16,
  parameter int V_ACTIVE = 480,
  parameter int VSYNC_W  = 2,
  parameter int VFP      = 10
) (
  input  logic dc_clk,
  input  logic dc_rst,
  input  logic enable,
  input  logic clr_underflow,
  output logic underflow,
  dc_timing_gen_if.master bus
);

  localparam int H_TOTAL = HSYNC_W + HBP + H_ACTIVE + HFP;
  localparam int V_TOTAL = V_ACTIVE + VFP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_END  = HW'(HSYNC_W);
  localparam logic [HW-1:0] ACT_BEG = HW'(HSYNC_W + HBP);
  localparam logic [HW-1:0] ACT_END = HW'(HSYNC_W + HBP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_END  = VW'(VSYNC_W);
  localparam logic [VW-1:0] VA_END  = VW'(V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            dv_q, dv_d;
  logic            fs_q, fs_d;
  logic [23:0]     pix_q, pix_d;
  logic            uf_q, uf_d;
  logic            run_d;
  logic            act_d;
  logic            ready;

  // Next position; a frame only ends when enable is low at its last cycle.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the position being entered so outputs line up with it.
  always_comb begin
    run_d   = (state_d == RUN);
    act_d   = run_d && (h_d >= ACT_BEG) && (h_d < ACT_END)
              && (v_d < VA_END);
    hsync_d = run_d && (h_d < HS_END);
    vsync_d = run_d && (v_d < VS_END);
    dv_d    = act_d;
    fs_d    = run_d && (h_d == '0) && (v_d == '0);
    ready   = act_d;
    pix_d   = pix_q;
    if (!run_d) begin
      pix_d = '0;
    end else if (ready) begin
      pix_d = bus.pix_in_valid ? bus.pix_in_data : 24'h0;
    end
    uf_d = uf_q | (ready & ~bus.pix_in_valid);
    if (clr_underflow) uf_d = 1'b0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge dc_clk or negedge dc_rst) begin
    if (!dc_rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      pix_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
      pix_q   <= pix_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.pix_in_ready = ready;
  assign bus.pixel_data   = pix_q;
  assign bus.data_valid   = dv_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.frame_start  = fs_q;
  assign underflow        = uf_q;

endmodule
